// File: rtl/prog_mem_loader.sv
// prog_mem_loader: word memory with checksum-verified byte-stream program loader
module prog_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_restart,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_run,
  output logic              ld_error,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERR} state_t;
  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          hold_q, hold_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                xfer;
  logic [15:0]         full_len;
  assign ld_ready     = (state_q != RUN) && (state_q != ERR);
  assign cpu_run      = state_q == RUN;
  assign ld_error     = state_q == ERR;
  assign words_loaded = words_q;
  assign cpu_rdata    = mem_q[cpu_addr];
  assign xfer         = ld_valid && ld_ready;
  assign full_len     = {len_q[15:8], ld_data};
  // next-state: restart wins over any byte or CPU write in the same cycle
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    csum_d    = csum_q;
    hold_d    = hold_q;
    wptr_d    = wptr_q;
    words_d   = words_q;
    mem_we    = 1'b0;
    mem_waddr = cpu_addr;
    mem_wdata = cpu_wdata;
    if (ld_restart) begin
      state_d = IDLE;
      len_d   = '0;
      csum_d  = '0;
      hold_d  = '0;
      wptr_d  = '0;
      words_d = '0;
    end else if (state_q == RUN) begin
      mem_we = cpu_rw;
    end else if (xfer) begin
      csum_d = (state_q == CSUM) ? csum_q : csum_q ^ ld_data;
      case (state_q)
        IDLE: begin
          len_d   = {ld_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d   = full_len;
          wptr_d  = '0;
          state_d = (full_len > 16'(DEPTH)) ? ERR : (full_len == 16'h0) ? CSUM : DATA_HI;
        end
        DATA_HI: begin
          hold_d  = ld_data;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          mem_we    = 1'b1;
          mem_waddr = wptr_q;
          mem_wdata = {hold_q, ld_data};
          wptr_d    = wptr_q + 1'b1;
          words_d   = words_q + 1'b1;
          state_d   = (16'(words_q) + 16'd1 == len_q) ? CSUM : DATA_HI;
        end
        CSUM: state_d = (ld_data == csum_q) ? RUN : ERR;
        default: ;
      endcase
    end
  end
  // loader state registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      hold_q  <= '0;
      wptr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      hold_q  <= hold_d;
      wptr_q  <= wptr_d;
      words_q <= words_d;
    end
  end
  // memory array keeps its contents across reset and restart
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: scoreboard bench for prog_mem_loader
module tb_prog_mem_loader;
  localparam int S_RDATA = 0, S_RUN = 1, S_ERR = 2, S_READY = 3, S_WORDS = 4;
  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } chk_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_restart = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_run;
  logic        ld_error;
  logic [10:0] words_loaded;
  chk_t        sb[$];
  logic [7:0]  tx[$];
  logic [7:0]  tx_csum;
  int          checks = 0;
  int          errors = 0;
  event        chk_ev;
  prog_mem_loader dut (
    .clk(clk), .reset(reset), .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_restart(ld_restart), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_run(cpu_run), .ld_error(ld_error), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_RDATA: return cpu_rdata;
      S_RUN:   return {15'h0, cpu_run};
      S_ERR:   return {15'h0, ld_error};
      S_READY: return {15'h0, ld_ready};
      default: return {5'h0, words_loaded};
    endcase
  endfunction
  // monitor: drains expectations on each negedge, or immediately on chk_ev
  initial forever begin
    @(negedge clk or chk_ev);
    while (sb.size() > 0) begin
      chk_t c;
      logic [15:0] got;
      c = sb.pop_front();
      got = observe(c.sel);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
      end
    end
  end
  task automatic expect_v(input string name, input int sel, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.sel = sel;
    c.exp = exp;
    sb.push_back(c);
  endtask
  task automatic expect_flags(input string tag, input logic run, input logic err,
                              input logic rdy, input logic [15:0] words);
    expect_v({tag, "_run"}, S_RUN, {15'h0, run});
    expect_v({tag, "_err"}, S_ERR, {15'h0, err});
    expect_v({tag, "_ready"}, S_READY, {15'h0, rdy});
    expect_v({tag, "_words"}, S_WORDS, words);
  endtask
  task automatic rd(input string name, input logic [9:0] a, input logic [15:0] exp);
    cpu_addr = a;
    expect_v(name, S_RDATA, exp);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic [7:0] b);
    tx.push_back(b);
    tx_csum = tx_csum ^ b;
  endtask
  task automatic add_word(input logic [15:0] w);
    add(w[15:8]);
    add(w[7:0]);
  endtask
  task automatic send();
    foreach (tx[i]) begin
      ld_data = tx[i];
      ld_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    tx.delete();
    tx_csum = 8'h00;
  endtask
  task automatic restart();
    ld_restart = 1'b1;
    @(posedge clk);
    #1;
    ld_restart = 1'b0;
  endtask
  initial begin
    tx_csum = 8'h00;
    #2;
    expect_flags("reset", 1'b0, 1'b0, 1'b1, 16'd0);
    ->chk_ev;
    @(posedge clk);
    #1;
    reset = 1'b1;
    add_word(16'h0003); add_word(16'h1234); add_word(16'hABCD); add_word(16'h5C00);
    add(tx_csum);
    send();
    expect_flags("good", 1'b1, 1'b0, 1'b0, 16'd3);
    rd("rd1", 10'd1, 16'hABCD);
    rd("rd0", 10'd0, 16'h1234);
    rd("rd2", 10'd2, 16'h5C00);
    cpu_addr = 10'h3FF; cpu_wdata = 16'hBEEF; cpu_rw = 1'b1;
    @(posedge clk);
    #1;
    cpu_rw = 1'b0;
    rd("run_wr", 10'h3FF, 16'hBEEF);
    restart();
    expect_flags("rst1", 1'b0, 1'b0, 1'b1, 16'd0);
    add_word(16'h0003); add_word(16'h1234); add_word(16'hABCD); add_word(16'h5C00);
    tx.push_back(8'h66);
    send();
    expect_flags("badcs", 1'b0, 1'b1, 1'b0, 16'd3);
    ld_data = 8'h12; ld_valid = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    expect_flags("err_hold", 1'b0, 1'b1, 1'b0, 16'd3);
    restart();
    expect_flags("rst2", 1'b0, 1'b0, 1'b1, 16'd0);
    add_word(16'h0002);
    send();
    cpu_addr = 10'h3FF; cpu_wdata = 16'h1111; cpu_rw = 1'b1;
    @(posedge clk);
    #1;
    cpu_rw = 1'b0;
    rd("hi_wr", 10'h3FF, 16'hBEEF);
    ld_data = 8'h77; ld_valid = 1'b1; ld_restart = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_restart = 1'b0;
    expect_flags("rst_drop", 1'b0, 1'b0, 1'b1, 16'd0);
    add_word(16'h0001); add_word(16'hA55A); add(tx_csum);
    send();
    expect_flags("after_drop", 1'b1, 1'b0, 1'b0, 16'd1);
    rd("drop_rd", 10'd0, 16'hA55A);
    restart();
    add_word(16'h0401);
    send();
    expect_flags("ovf", 1'b0, 1'b1, 1'b0, 16'd0);
    rd("ovf_mem", 10'd0, 16'hA55A);
    restart();
    add_word(16'h0000); add(tx_csum);
    send();
    expect_flags("zero", 1'b1, 1'b0, 1'b0, 16'd0);
    restart();
    add_word(16'h0400);
    for (int i = 0; i < 1024; i++) add_word(16'(i * 7) ^ 16'hC3A0);
    add(tx_csum);
    send();
    expect_flags("full", 1'b1, 1'b0, 1'b0, 16'h0400);
    rd("full_last", 10'h3FF, 16'(1023 * 7) ^ 16'hC3A0);
    rd("full_first", 10'h000, 16'hC3A0);
    restart();
    add_word(16'h0003); add_word(16'h1111); add_word(16'h2222); add(8'h33);
    send();
    #2;
    reset = 1'b0;
    #1;
    expect_flags("async", 1'b0, 1'b0, 1'b1, 16'd0);
    ->chk_ev;
    rd("async_w0", 10'd0, 16'h1111);
    rd("async_w1", 10'd1, 16'h2222);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expect_flags("post_rst", 1'b0, 1'b0, 1'b1, 16'd0);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
